// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, imem req/ack, registered inst to decode.
// Optional FETCH_CNT_EN adds the fetch_count accepted-instruction counter.
module inst_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_exc
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0]     fetch_count
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_HOLD,
    S_DISCARD,
    S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [31:0]     inst_q, inst_d;
  logic            mis_q, mis_d;
  logic            tgt_misal;
  logic            pending;

  assign tgt_misal = |redirect_pc[1:0];
  // a request is on the bus and will not complete this cycle
  assign pending = (state_q == S_FETCH || state_q == S_DISCARD)
                 && !imem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_START;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      inst_q  <= NOP;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    mis_d   = mis_q;
    if (redirect) begin
      pc_d  = redirect_pc;
      mis_d = tgt_misal;
      if (pending)
        state_d = S_DISCARD;
      else
        state_d = tgt_misal ? S_FAULT : S_FETCH;
    end else begin
      case (state_q)
        S_START: state_d = S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            inst_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            pc_d    = pc_q + XLEN'(4);
            state_d = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imem_ack)
            state_d = mis_q ? S_FAULT : S_FETCH;
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_START;
      endcase
    end
    // the address only moves when a fresh request begins
    if (state_d == S_FETCH)
      addr_d = {pc_d[XLEN-1:2], 2'b00};
    else
      addr_d = addr_q;
  end

  always_comb begin
    imem_req   = (state_q == S_FETCH) || (state_q == S_DISCARD);
    inst_valid = (state_q == S_HOLD);
  end

  assign imem_addr    = addr_q;
  assign inst         = inst_q;
  assign pc           = pc_q;
  assign misalign_exc = mis_q;

`ifdef FETCH_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inst_valid && inst_ready && !redirect)
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign fetch_count = cnt_q;
`endif

endmodule
